// File: rtl/ibex_instr_bus_arb.sv
// ibex_instr_bus_arb
//   Shares the instruction-side memory port between the prefetch buffer (M0)
//   and a secondary fetch requester (M1). The request path is a pure
//   combinational mux. A small ID FIFO records the owner of each granted
//   transaction, so in-order responses are steered back to whoever issued them.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   mX_req_i / mX_addr_i      master request and address, held until granted
//   mX_gnt_o                  grant, seen only by the selected master
//   mX_rvalid_o               response valid for the owning master
//   mX_rdata_o / mX_err_o     response data and error, broadcast whenever
//                             instr_rvalid_i is high
//   instr_*                   memory side (req/gnt/rvalid, pipelined, in order)
//   busy_o                    outstanding transactions, or a request on the bus
module ibex_instr_bus_arb #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,

  output logic        busy_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic                      rr_ptr_q, rr_ptr_d;
  logic                      lock_q, lock_d;
  logic                      owner_q, owner_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [MaxOutstanding-1:0] id_q, id_d;

  logic        full;
  logic        sel;
  logic        req_sel;
  logic [29:0] addr_sel;
  logic        grant;
  logic        push, pop;
  logic        head;
  logic        fifo_nonempty;
  logic        spurious_rsp;
  logic        lock_dropped;
  logic        unused_addr_lsbs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Word-aligned bus: the byte offset of the masters' addresses is discarded.
  assign unused_addr_lsbs = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  always_comb begin
    full          = (count_q == CntW'(MaxOutstanding));
    fifo_nonempty = (count_q != '0);

    // A stalled request keeps its owner so the bus address cannot change
    // underneath the memory before it grants.
    if (lock_q) begin
      sel = owner_q;
    end else if (m0_req_i && m1_req_i) begin
      sel = rr_ptr_q;
    end else begin
      sel = m1_req_i;
    end

    req_sel  = sel ? m1_req_i : m0_req_i;
    addr_sel = sel ? m1_addr_i[31:2] : m0_addr_i[31:2];

    // Full is judged on the registered count only, so a same-cycle rvalid
    // never opens a combinational path into instr_req_o.
    instr_req_o  = req_sel & ~full;
    instr_addr_o = {addr_sel, 2'b00};

    grant    = instr_req_o & instr_gnt_i;
    m0_gnt_o = grant & ~sel;
    m1_gnt_o = grant & sel;

    // Lock follows a presented-but-ungranted request; anything else clears it,
    // including the locked owner withdrawing its request.
    lock_d   = instr_req_o & ~instr_gnt_i;
    owner_d  = lock_d ? sel : owner_q;
    rr_ptr_d = grant ? ~sel : rr_ptr_q;

    push = grant;
    pop  = instr_rvalid_i & fifo_nonempty;
    head = id_q[rd_ptr_q];

    id_d = id_q;
    if (push) begin
      id_d[wr_ptr_q] = sel;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    m0_rvalid_o = pop & ~head;
    m1_rvalid_o = pop & head;
    m0_rdata_o  = instr_rvalid_i ? instr_rdata_i : '0;
    m1_rdata_o  = instr_rvalid_i ? instr_rdata_i : '0;
    m0_err_o    = instr_rvalid_i & instr_err_i;
    m1_err_o    = instr_rvalid_i & instr_err_i;

    busy_o = fifo_nonempty | instr_req_o;

    spurious_rsp = instr_rvalid_i & ~fifo_nonempty;
    lock_dropped = lock_q & ~req_sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= 1'b0;
      lock_q   <= 1'b0;
      owner_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ID storage is only read behind a nonzero count, so it may stay unreset.
  if (ResetAll) begin : g_id_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        id_q <= '0;
      end else begin
        id_q <= id_d;
      end
    end
  end else begin : g_id_norst
    always_ff @(posedge clk_i) begin
      id_q <= id_d;
    end
  end

`ifndef SYNTHESIS
  // Protocol observers: a response with nothing outstanding is dropped, and a
  // locked owner must keep its request up until granted.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!spurious_rsp)
        else $info("ibex_instr_bus_arb: rvalid with no outstanding transaction dropped");
      assert (!lock_dropped)
        else $info("ibex_instr_bus_arb: locked owner withdrew its request");
    end
  end
`endif

endmodule
